// File: rtl/rr_chan_merge.sv
// rr_chan_merge
//   N-channel merge stage. Every input channel owns a small private FIFO; a
//   round-robin arbiter drains the FIFOs into a single registered valid/ready
//   output stream. Each output word is tagged with its source channel index.
//
// Parameters
//   NUM_CH  number of input channels (2..16)
//   DATA_W  payload width in bits
//   DEPTH   entries per channel FIFO (power of 2, >= 2)
//   CH_W    channel tag width, derived from NUM_CH
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    per-channel push request
//   in_data     packed payloads, channel i at [i*DATA_W +: DATA_W]
//   in_ready    per-channel "FIFO not full" (registered count only)
//   out_valid   output register holds a word
//   out_data    output payload
//   out_ch      source channel of out_data
//   out_ready   consumer accepts the output word
//   fifo_empty  per-channel FIFO empty status
//
// Optional feature (macro RR_CHAN_MERGE_STATS_EN)
//   clr_stats   synchronous clear of all grant counters (wins over increment)
//   gnt_cnt     one saturating 16-bit grant counter per channel,
//               channel i at [i*16 +: 16]
module rr_chan_merge #(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  input  logic                     out_ready,
`ifdef RR_CHAN_MERGE_STATS_EN
  input  logic                     clr_stats,
  output logic [NUM_CH*16-1:0]     gnt_cnt,
`endif
  output logic [NUM_CH-1:0]        fifo_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Per-channel FIFO storage and bookkeeping.
  logic [DATA_W-1:0] r_mem    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  r_rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  r_count  [NUM_CH];

  // Arbiter history and output register.
  logic [CH_W-1:0]   r_last_gnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [CH_W-1:0]   r_out_ch;

  logic [NUM_CH-1:0] w_push;
  logic [NUM_CH-1:0] w_pop;
  logic [NUM_CH-1:0] w_nonempty;
  logic              w_load_en;
  logic              w_gnt_any;
  logic [CH_W-1:0]   w_gnt_idx;
  logic [CH_W-1:0]   w_cand;
  logic [DATA_W-1:0] w_head;

  // Status flags come from the registered count only: a full FIFO refuses a
  // push even in a cycle where it is being popped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_status
    assign w_nonempty[g] = (r_count[g] != '0);
    assign in_ready[g]   = (r_count[g] != CNT_W'(DEPTH));
    assign fifo_empty[g] = ~w_nonempty[g];
    assign w_push[g]     = in_valid[g] & in_ready[g];
    assign w_pop[g]      = w_load_en & w_gnt_any & (w_gnt_idx == CH_W'(g));
  end

  // The output register may take a new word when it is empty or being drained.
  assign w_load_en = !r_out_valid || out_ready;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      w_cand = CH_W'((int'(r_last_gnt) + off) % NUM_CH);
      if (!w_gnt_any && w_nonempty[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_head = r_mem[w_gnt_idx][r_rd_ptr[w_gnt_idx]];

  // Pointers and occupancy. Pointers wrap naturally since DEPTH is a power
  // of two; a push and pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_push[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
        if (w_pop[i])  r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + 1'b1;
          2'b01:   r_count[i] <= r_count[i] - 1'b1;
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  // NOTE: the storage array has no reset; its contents are only ever read
  // behind a non-zero count, so resetting it would cost logic for nothing.
  // Only pushing channels write, so idle-channel in_data never reaches it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_push[i]) r_mem[i][r_wr_ptr[i]] <= in_data[i*DATA_W +: DATA_W];
    end
  end

  // Output register and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_last_gnt  <= CH_W'(NUM_CH - 1);
    end else if (w_load_en) begin
      if (w_gnt_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_head;
        r_out_ch    <= w_gnt_idx;
        r_last_gnt  <= w_gnt_idx;
      end else begin
        // Nothing to send: drop valid, keep the last payload and tag.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;

`ifdef RR_CHAN_MERGE_STATS_EN
  // Per-channel grant counters, saturating at all ones.
  logic [15:0] r_gnt_cnt [NUM_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) r_gnt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_stats) begin
          r_gnt_cnt[i] <= '0;
        end else if (w_pop[i] && (r_gnt_cnt[i] != 16'hFFFF)) begin
          r_gnt_cnt[i] <= r_gnt_cnt[i] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stats
    assign gnt_cnt[g*16 +: 16] = r_gnt_cnt[g];
  end
`endif

endmodule

// File: tb/tb_rr_chan_merge.sv
// Testbench for rr_chan_merge (NUM_CH=4, DATA_W=32, DEPTH=4).
// Directed vector table for the round-robin drain, plus hand-written
// sequences for backpressure, stall stability, simultaneous push/pop,
// mid-stream reset and (when RR_CHAN_MERGE_STATS_EN is defined) the
// grant counters.
module tb_rr_chan_merge;

  localparam int NUM_CH = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;
  logic         out_ready;
  logic [3:0]   fifo_empty;
`ifdef RR_CHAN_MERGE_STATS_EN
  logic         clr_stats;
  logic [63:0]  gnt_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rr_chan_merge #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_ready  (out_ready),
`ifdef RR_CHAN_MERGE_STATS_EN
    .clr_stats  (clr_stats),
    .gnt_cnt    (gnt_cnt),
`endif
    .fifo_empty (fifo_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   vld;
    logic         ordy;
    logic [127:0] data;
    logic         ev;
    logic [31:0]  ed;
    logic [1:0]   ech;
    logic [3:0]   erdy;
    logic [3:0]   eemp;
  } vec_t;

  vec_t vecs [10];

  // Scoreboard for the channel-3 push/pop sequence.
  logic [31:0] q [$];
  logic        mov;
  logic [31:0] mdata;
  logic [31:0] next_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mstep(input logic vld, input logic ordy);
    logic push_ok;
    logic ld;
    in_valid          = {vld, 3'b000};
    in_data[96 +: 32] = next_word;
    out_ready         = ordy;
    push_ok = vld && (q.size() != DEPTH);
    ld      = !mov || ordy;
    step();
    if (ld) begin
      if (q.size() != 0) begin
        mdata = q.pop_front();
        mov   = 1'b1;
      end else begin
        mov = 1'b0;
      end
    end
    if (push_ok) begin
      q.push_back(next_word);
      next_word++;
    end
    check("pp_valid", out_valid, mov);
    if (mov) begin
      check("pp_data", out_data, mdata);
      check("pp_ch", out_ch, 2'd3);
    end
    check("pp_in_ready", in_ready, {q.size() != DEPTH, 3'b111});
    check("pp_empty", fifo_empty, {q.size() == 0, 3'b111});
  endtask

  initial begin
    logic [31:0] exp_d [8];
    logic [1:0]  exp_c [8];

    vecs[0] = '{vld:4'hF, ordy:1'b0, data:{32'h30, 32'h20, 32'h10, 32'h00}, ev:1'b0, ed:32'h00, ech:2'd0, erdy:4'hF, eemp:4'h0};
    vecs[1] = '{vld:4'hF, ordy:1'b0, data:{32'h31, 32'h21, 32'h11, 32'h01}, ev:1'b1, ed:32'h00, ech:2'd0, erdy:4'hF, eemp:4'h0};
    vecs[2] = '{vld:4'h0, ordy:1'b1, data:128'h0, ev:1'b1, ed:32'h10, ech:2'd1, erdy:4'hF, eemp:4'h0};
    vecs[3] = '{vld:4'h0, ordy:1'b1, data:128'h0, ev:1'b1, ed:32'h20, ech:2'd2, erdy:4'hF, eemp:4'h0};
    vecs[4] = '{vld:4'h0, ordy:1'b1, data:128'h0, ev:1'b1, ed:32'h30, ech:2'd3, erdy:4'hF, eemp:4'h0};
    vecs[5] = '{vld:4'h0, ordy:1'b1, data:128'h0, ev:1'b1, ed:32'h01, ech:2'd0, erdy:4'hF, eemp:4'h1};
    vecs[6] = '{vld:4'h0, ordy:1'b1, data:128'h0, ev:1'b1, ed:32'h11, ech:2'd1, erdy:4'hF, eemp:4'h3};
    vecs[7] = '{vld:4'h0, ordy:1'b1, data:128'h0, ev:1'b1, ed:32'h21, ech:2'd2, erdy:4'hF, eemp:4'h7};
    vecs[8] = '{vld:4'h0, ordy:1'b1, data:128'h0, ev:1'b1, ed:32'h31, ech:2'd3, erdy:4'hF, eemp:4'hF};
    vecs[9] = '{vld:4'h0, ordy:1'b1, data:128'h0, ev:1'b0, ed:32'h31, ech:2'd3, erdy:4'hF, eemp:4'hF};

    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef RR_CHAN_MERGE_STATS_EN
    clr_stats = 1'b0;
`endif

    // ---- Reset state ----
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_ch", out_ch, 2'd0);
    check("rst_in_ready", in_ready, 4'hF);
    check("rst_empty", fifo_empty, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- Round-robin fairness table ----
    for (int v = 0; v < 10; v++) begin
      in_valid  = vecs[v].vld;
      in_data   = vecs[v].data;
      out_ready = vecs[v].ordy;
      step();
      check($sformatf("rr%0d_valid", v), out_valid, vecs[v].ev);
      check($sformatf("rr%0d_data", v), out_data, vecs[v].ed);
      check($sformatf("rr%0d_ch", v), out_ch, vecs[v].ech);
      check($sformatf("rr%0d_in_ready", v), in_ready, vecs[v].erdy);
      check($sformatf("rr%0d_empty", v), fifo_empty, vecs[v].eemp);
    end

    // ---- Full FIFO / backpressure on channel 2 ----
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid          = 4'b0100;
      in_data           = '0;
      in_data[64 +: 32] = 32'hA0 + k;
      step();
      check($sformatf("full_push%0d_in_ready", k), in_ready, (k == 4) ? 4'hB : 4'hF);
      if (k >= 1) check($sformatf("full_push%0d_head", k), out_data, 32'hA0);
    end
    in_data[64 +: 32] = 32'hA5;
    step();
    check("full_refuse_in_ready", in_ready, 4'hB);
    check("full_refuse_out", out_data, 32'hA0);
    in_valid  = '0;
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      step();
      check($sformatf("full_drain%0d_valid", k), out_valid, 1'b1);
      check($sformatf("full_drain%0d_data", k), out_data, 32'hA0 + k);
      check($sformatf("full_drain%0d_ch", k), out_ch, 2'd2);
    end
    step();
    check("full_drain_done", out_valid, 1'b0);
    check("full_drain_empty", fifo_empty, 4'hF);

    // ---- Stall stability ----
    out_ready        = 1'b0;
    in_valid         = 4'b0001;
    in_data          = '0;
    in_data[0 +: 32] = 32'hB0;
    step();
    in_valid = '0;
    step();
    check("stall_load_valid", out_valid, 1'b1);
    check("stall_load_data", out_data, 32'hB0);
    for (int k = 0; k < 10; k++) begin
      in_valid          = 4'b1010;
      in_data[32 +: 32] = 32'hC0 + k;
      in_data[96 +: 32] = 32'hD0 + k;
      step();
      check($sformatf("stall%0d_valid", k), out_valid, 1'b1);
      check($sformatf("stall%0d_data", k), out_data, 32'hB0);
      check($sformatf("stall%0d_ch", k), out_ch, 2'd0);
    end
    check("stall_in_ready", in_ready, 4'h5);
    check("stall_empty", fifo_empty, 4'h5);
    exp_d = '{32'hC0, 32'hD0, 32'hC1, 32'hD1, 32'hC2, 32'hD2, 32'hC3, 32'hD3};
    exp_c = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd3};
    in_valid  = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("stall_drain%0d_data", k), out_data, exp_d[k]);
      check($sformatf("stall_drain%0d_ch", k), out_ch, exp_c[k]);
    end
    step();
    check("stall_drain_done", out_valid, 1'b0);

    // ---- Simultaneous push/pop on channel 3 ----
    mov       = 1'b0;
    mdata     = '0;
    next_word = 32'hE0;
    in_data   = '0;
    for (int k = 0; k < 3; k++) mstep(1'b1, 1'b0);
    mstep(1'b1, 1'b1);
    for (int k = 0; k < 20; k++) mstep(1'($urandom_range(1)), 1'($urandom_range(1)));
    for (int k = 0; k < 8; k++) mstep(1'b0, 1'b1);

    // ---- Reset mid-stream with 3 words buffered in channel 1 ----
    out_ready = 1'b0;
    in_data   = '0;
    for (int k = 0; k < 4; k++) begin
      in_valid          = 4'b0010;
      in_data[32 +: 32] = 32'hF0 + k;
      step();
    end
    in_valid = '0;
    check("mid_pre_valid", out_valid, 1'b1);
    check("mid_pre_empty", fifo_empty, 4'hD);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 4'hF);
    check("mid_rst_empty", fifo_empty, 4'hF);
    check("mid_rst_data", out_data, 32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("mid_after%0d_valid", k), out_valid, 1'b0);
    end

`ifdef RR_CHAN_MERGE_STATS_EN
    // ---- Grant counters ----
    in_valid         = 4'b0001;
    in_data[0 +: 32] = 32'h55;
    out_ready        = 1'b1;
    for (int k = 0; k < 10; k++) step();
    check("stats_cnt9", gnt_cnt[15:0], 16'd9);
    for (int k = 0; k < 69995; k++) step();
    check("stats_sat", gnt_cnt[15:0], 16'hFFFF);
    check("stats_others", gnt_cnt[63:16], 48'h0);
    clr_stats = 1'b1;
    step();
    check("stats_clr", gnt_cnt[15:0], 16'd0);
    clr_stats = 1'b0;
    step();
    check("stats_after_clr", gnt_cnt[15:0], 16'd1);
    in_valid = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rr_chan_merge.md
Name: rr_chan_merge

Overview:
- Parameterised N-channel merge stage: each input channel has a small private FIFO; a round-robin arbiter drains the FIFOs into one registered valid/ready output stream tagged with the source channel index.
- Sits between per-channel producers and a single shared consumer bus; replaces fixed 2-channel, unbuffered muxing with configurable channel count, width and per-channel buffering.

Parameters:
NUM_CH, 4, number of input channels (2..16)
DATA_W, 32, payload width in bits (>=1)
DEPTH, 4, entries per channel FIFO (power of 2, >=2)
CH_W, $clog2(NUM_CH), width of channel tag (derived localparam, not overridable)

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  NUM_CH  per-channel data valid
in_data  in  NUM_CH*DATA_W  packed payloads, channel i at [i*DATA_W +: DATA_W]
in_ready  out  NUM_CH  per-channel FIFO not full
out_valid  out  1  output holds a word
out_data  out  DATA_W  output payload
out_ch  out  CH_W  source channel of out_data
out_ready  in  1  consumer accepts
fifo_empty  out  NUM_CH  per-channel FIFO empty flag (status)

Behaviour:
- Reset (async assert, sync deassert by integrator): all FIFO pointers/counts = 0; in_ready = all 1s; fifo_empty = all 1s; out_valid = 0; out_data = 0; out_ch = 0; round-robin pointer last_gnt = NUM_CH-1 (so channel 0 has first priority).
- Push: channel i writes when in_valid[i] && in_ready[i] at a rising edge. in_ready[i] = (count[i] != DEPTH), from registered count only; it does not look ahead at a same-cycle pop, so a full FIFO refuses a push even while being popped.
- Pointers: wr/rd pointers are $clog2(DEPTH) bits and wrap naturally; count is $clog2(DEPTH)+1 bits. A simultaneous push and pop on the same channel leaves count unchanged.
- Output stage: a single register. load_en = !out_valid || out_ready.
- Arbiter: when load_en, candidates = channels with count != 0. Grant = first candidate searching last_gnt+1, last_gnt+2, ... modulo NUM_CH. On grant: pop that FIFO; out_data <= head; out_ch <= index; out_valid <= 1; last_gnt <= index.
- When load_en and no candidates: out_valid <= 0; out_data/out_ch hold their last values. last_gnt is unchanged.
- When !load_en (stalled): out_valid/out_data/out_ch held stable; no pops; last_gnt unchanged.
- Latency: word pushed at edge k is visible in count after edge k and can be granted at edge k+1. out_valid is high in the cycle after edge k+1 if the stage is free and the arbiter picks that channel.
- Throughput: one word per cycle sustained when out_ready is held 1.
- Ordering: per-channel FIFO order is preserved. No starvation: any non-empty channel is granted within NUM_CH grants.
- fifo_empty[i] = (count[i] == 0), registered-derived.
- Reset mid-operation: all buffered data is discarded immediately; outputs return to reset values asynchronously.
- X-safety: in_data for non-pushing channels is never written into storage.

Optional Feature:
- Macro RR_CHAN_MERGE_STATS_EN.
- Defined: adds output port gnt_cnt [NUM_CH*16] with one 16-bit counter per channel. The counter increments on each grant to that channel and saturates at 16'hFFFF. It resets to 0 and is cleared synchronously by a new input clr_stats (1 bit); clear wins over a same-cycle increment.
- Not defined: no gnt_cnt or clr_stats ports and no counter logic; all other behaviour identical.

Test Plan:
- Reset check: rst_n=0 mid-stream with 3 words buffered in ch1 -> immediately out_valid=0, in_ready=4'b1111, fifo_empty=4'b1111. After release, nothing is emitted without new pushes.
- Fairness: preload ch0..ch3 with 2 words each (ch i data = 16*i + n), then out_ready=1 -> out_ch sequence 0,1,2,3,0,1,2,3, one per cycle; data 0x00,0x10,0x20,0x30,0x01,0x11,0x21,0x31.
- Full/backpressure: out_ready=0, push 5 words into ch2 with DEPTH=4 -> 1 word in output register, 4 in FIFO. in_ready[2]=0 after the 5th accept; a 6th attempt is not taken. Then out_ready=1 -> all 5 emerge in order.
- Stall stability: out_valid=1, out_ready=0 for 10 cycles while other channels push -> out_data/out_ch unchanged every cycle.
- Simultaneous push/pop: ch3 at count 2, push and pop in the same cycle -> count stays 2, and order is preserved across 20 random cycles.
- Stats (macro defined): 70000 grants to ch0 -> gnt_cnt[15:0]=16'hFFFF. Asserting clr_stats during a grant -> 0 next cycle.
